// File: rtl/dii_package.sv
// Shared debug-interconnect types.
//   dii_flit : one 16-bit flit with an end-of-packet marker and a valid bit.
package dii_package;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic        valid;
  } dii_flit;

endpackage

// File: rtl/dii_packet_buffer.sv
// Flit buffer between a debug module and its debug-ring local input port.
// Stores up to BUF_SIZE flits in FIFO order with first-word fall-through.
//
// Parameters
//   BUF_SIZE   : storage depth in flits; must be a power of two, at least 2
//   FULLPACKET : 1 = store-and-forward (release only complete packets),
//                0 = cut-through (release any stored flit)
//
// Ports
//   clk            : clock, all state updates on the rising edge
//   rst            : asynchronous active-high reset, discards all stored flits
//   flit_in        : flit from the debug module
//   flit_in_ready  : buffer accepts flit_in this cycle (not full)
//   flit_out       : head flit toward the ring (data/last valid when valid=1)
//   flit_out_ready : ring accepts flit_out this cycle
//   fill           : number of flits stored
//   packet_cnt     : number of complete packets (last flit stored) held
module dii_packet_buffer
  import dii_package::*;
#(
  parameter int unsigned BUF_SIZE   = 4,
  parameter bit          FULLPACKET = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  dii_flit                       flit_in,
  output logic                          flit_in_ready,
  output dii_flit                       flit_out,
  input  logic                          flit_out_ready,
  output logic [$clog2(BUF_SIZE+1)-1:0] fill,
  output logic [$clog2(BUF_SIZE+1)-1:0] packet_cnt
);

  localparam int unsigned PTR_W = $clog2(BUF_SIZE);
  localparam int unsigned CNT_W = $clog2(BUF_SIZE + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_SIZE);

  // Each entry holds {last, data}; valid is implied by occupancy.
  logic [16:0]      mem [BUF_SIZE];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             drain;

  logic [16:0] head;
  logic        is_full;
  logic        not_empty;
  logic        out_valid;
  logic        push;
  logic        pop;
  logic        push_last;
  logic        pop_last;

  assign head      = mem[rd_ptr];
  assign is_full   = (fill == FULL_CNT);
  assign not_empty = (fill != '0);

  // Readiness depends only on the stored count, never on the ring side, so a
  // full buffer refuses a push even in a cycle where it pops.
  assign flit_in_ready = !is_full;

  // Store-and-forward releases a flit once a whole packet is held, or when the
  // buffer fills with a partial packet that can never complete inside it.
  // In the latter case drain keeps the packet streaming until its last flit.
  always_comb begin
    if (FULLPACKET) begin
      out_valid = not_empty && ((packet_cnt != '0) || is_full || drain);
    end else begin
      out_valid = not_empty;
    end
  end

  always_comb begin
    flit_out.data  = head[15:0];
    flit_out.last  = head[16];
    flit_out.valid = out_valid;
  end

  assign push      = flit_in.valid && flit_in_ready;
  assign pop       = out_valid && flit_out_ready;
  assign push_last = push && flit_in.last;
  assign pop_last  = pop && head[16];

  // Storage: data path only, contents survive reset and are ignored while
  // the occupancy count says they are empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {flit_in.last, flit_in.data};
    end
  end

  // Control state: pointers wrap naturally because BUF_SIZE is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill       <= '0;
      packet_cnt <= '0;
      drain      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      case ({push, pop})
        2'b10:   fill <= fill + CNT_W'(1);
        2'b01:   fill <= fill - CNT_W'(1);
        default: fill <= fill;
      endcase

      case ({push_last, pop_last})
        2'b10:   packet_cnt <= packet_cnt + CNT_W'(1);
        2'b01:   packet_cnt <= packet_cnt - CNT_W'(1);
        default: packet_cnt <= packet_cnt;
      endcase

      if (pop_last) begin
        drain <= 1'b0;
      end else if (is_full && (packet_cnt == '0)) begin
        drain <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dii_packet_buffer.sv
module tb_dii_packet_buffer;
  import dii_package::*;

  logic       clk;
  logic       rst;

  dii_flit    sf_in;
  logic       sf_in_ready;
  dii_flit    sf_out;
  logic       sf_out_ready;
  logic [2:0] sf_fill;
  logic [2:0] sf_pkt;

  dii_flit    ct_in;
  logic       ct_in_ready;
  dii_flit    ct_out;
  logic       ct_out_ready;
  logic [2:0] ct_fill;
  logic [2:0] ct_pkt;

  int n_checks = 0;
  int n_fail   = 0;

  dii_packet_buffer #(.BUF_SIZE(4), .FULLPACKET(1'b1)) u_sf (
    .clk            (clk),
    .rst            (rst),
    .flit_in        (sf_in),
    .flit_in_ready  (sf_in_ready),
    .flit_out       (sf_out),
    .flit_out_ready (sf_out_ready),
    .fill           (sf_fill),
    .packet_cnt     (sf_pkt)
  );

  dii_packet_buffer #(.BUF_SIZE(4), .FULLPACKET(1'b0)) u_ct (
    .clk            (clk),
    .rst            (rst),
    .flit_in        (ct_in),
    .flit_in_ready  (ct_in_ready),
    .flit_out       (ct_out),
    .flit_out_ready (ct_out_ready),
    .fill           (ct_fill),
    .packet_cnt     (ct_pkt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are read
  // one or two time units after it, well away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sf(input logic v, input logic l, input logic [15:0] d);
    sf_in.valid = v;
    sf_in.last  = l;
    sf_in.data  = d;
  endtask

  task automatic set_ct(input logic v, input logic l, input logic [15:0] d);
    ct_in.valid = v;
    ct_in.last  = l;
    ct_in.data  = d;
  endtask

  initial begin
    int sent;
    int got;
    logic acc;

    rst = 1'b1;
    set_sf(1'b0, 1'b0, 16'h0);
    set_ct(1'b0, 1'b0, 16'h0);
    sf_out_ready = 1'b0;
    ct_out_ready = 1'b0;

    // Reset state
    #2;
    check("rst_sf_fill",  sf_fill, 0);
    check("rst_sf_pkt",   sf_pkt, 0);
    check("rst_sf_valid", sf_out.valid, 0);
    check("rst_ct_valid", ct_out.valid, 0);
    step();
    step();
    rst = 1'b0;
    #1;
    check("post_rst_sf_ready", sf_in_ready, 1);
    check("post_rst_ct_ready", ct_in_ready, 1);

    // Store-and-forward: 3-flit packet held back until its last flit is in
    sf_out_ready = 1'b1;
    set_sf(1'b1, 1'b0, 16'h0001);
    #1;
    check("sf3_valid_c0", sf_out.valid, 0);
    step();
    set_sf(1'b1, 1'b0, 16'h0002);
    #1;
    check("sf3_valid_c1", sf_out.valid, 0);
    step();
    set_sf(1'b1, 1'b1, 16'h0003);
    #1;
    check("sf3_valid_c2", sf_out.valid, 0);
    step();
    set_sf(1'b0, 1'b0, 16'h0);
    #1;
    check("sf3_valid_c3", sf_out.valid, 1);
    check("sf3_data0", sf_out.data, 16'h0001);
    check("sf3_pkt_1", sf_pkt, 1);
    step();
    check("sf3_data1", sf_out.data, 16'h0002);
    check("sf3_last1", sf_out.last, 0);
    step();
    check("sf3_data2", sf_out.data, 16'h0003);
    check("sf3_last2", sf_out.last, 1);
    step();
    check("sf3_empty_valid", sf_out.valid, 0);
    check("sf3_pkt_0", sf_pkt, 0);
    check("sf3_fill_0", sf_fill, 0);

    // Store-and-forward: oversized 6-flit packet must drain instead of deadlocking
    sf_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_sf(1'b1, 1'b0, 16'h0010 + 16'(i));
      step();
    end
    set_sf(1'b1, 1'b0, 16'h0014);
    #1;
    check("big_full_ready", sf_in_ready, 0);
    check("big_full_valid", sf_out.valid, 1);
    check("big_full_fill", sf_fill, 4);
    sf_out_ready = 1'b1;
    #1;
    sent = 4;
    got  = 0;
    for (int cyc = 0; cyc < 30 && got < 6; cyc++) begin
      if (sf_out.valid && sf_out_ready) begin
        check("big_data", sf_out.data, 16'h0010 + 16'(got));
        check("big_last", sf_out.last, (got == 5) ? 1 : 0);
        got++;
      end
      acc = sf_in.valid && sf_in_ready;
      step();
      if (acc) sent++;
      if (sent < 6) set_sf(1'b1, (sent == 5), 16'h0010 + 16'(sent));
      else          set_sf(1'b0, 1'b0, 16'h0);
      #1;
    end
    check("big_pop_count", got, 6);
    check("big_fill_0", sf_fill, 0);
    // Drain must be clear now: a fresh partial packet is held back again
    set_sf(1'b1, 1'b0, 16'h0016);
    step();
    set_sf(1'b0, 1'b0, 16'h0);
    #1;
    check("drain_cleared_valid", sf_out.valid, 0);
    set_sf(1'b1, 1'b1, 16'h0017);
    step();
    set_sf(1'b0, 1'b0, 16'h0);
    #1;
    check("tail_pkt_valid", sf_out.valid, 1);
    check("tail_pkt_d0", sf_out.data, 16'h0016);
    step();
    check("tail_pkt_d1", sf_out.data, 16'h0017);
    step();
    check("tail_pkt_fill", sf_fill, 0);

    // Cut-through: one-cycle latency
    ct_out_ready = 1'b1;
    set_ct(1'b1, 1'b1, 16'hA5A5);
    #1;
    check("ct_valid_n", ct_out.valid, 0);
    step();
    set_ct(1'b0, 1'b0, 16'h0);
    #1;
    check("ct_valid_n1", ct_out.valid, 1);
    check("ct_data_n1", ct_out.data, 16'hA5A5);
    check("ct_fill_n1", ct_fill, 1);
    step();
    check("ct_fill_n2", ct_fill, 0);
    check("ct_valid_n2", ct_out.valid, 0);

    // Full buffer refuses a push even while popping
    ct_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_ct(1'b1, 1'b1, 16'h0020 + 16'(i));
      step();
    end
    set_ct(1'b1, 1'b1, 16'h0024);
    #1;
    check("full_fill", ct_fill, 4);
    check("full_pkt", ct_pkt, 4);
    check("full_ready", ct_in_ready, 0);
    ct_out_ready = 1'b1;
    #1;
    check("full_pop_data", ct_out.data, 16'h0020);
    check("full_ready_w_pop", ct_in_ready, 0);
    step();
    check("full_after_fill", ct_fill, 3);
    check("full_after_pkt", ct_pkt, 3);
    check("full_after_ready", ct_in_ready, 1);
    check("full_after_data", ct_out.data, 16'h0021);
    step();
    set_ct(1'b0, 1'b0, 16'h0);
    #1;
    check("pushpop_fill", ct_fill, 3);
    check("pushpop_pkt", ct_pkt, 3);
    check("pushpop_d0", ct_out.data, 16'h0022);
    step();
    check("pushpop_d1", ct_out.data, 16'h0023);
    step();
    check("pushpop_d2", ct_out.data, 16'h0024);
    step();
    check("pushpop_empty", ct_fill, 0);

    // Continuous 1-flit packets through the store-and-forward buffer
    sf_out_ready = 1'b0;
    set_sf(1'b1, 1'b1, 16'h0030);
    step();
    set_sf(1'b1, 1'b1, 16'h0031);
    step();
    set_sf(1'b0, 1'b0, 16'h0);
    #1;
    check("stream_pre_fill", sf_fill, 2);
    check("stream_pre_pkt", sf_pkt, 2);
    sf_out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_sf(1'b1, 1'b1, 16'h0032 + 16'(i));
      #1;
      check("stream_valid", sf_out.valid, 1);
      check("stream_data", sf_out.data, 16'h0030 + 16'(i));
      check("stream_fill", sf_fill, 2);
      check("stream_pkt", sf_pkt, 2);
      step();
    end
    set_sf(1'b0, 1'b0, 16'h0);
    #1;
    check("stream_tail0", sf_out.data, 16'h0044);
    step();
    check("stream_tail1", sf_out.data, 16'h0045);
    step();
    check("stream_end_fill", sf_fill, 0);

    // Reset with two complete packets stored
    sf_out_ready = 1'b0;
    set_sf(1'b1, 1'b1, 16'h0040);
    step();
    set_sf(1'b1, 1'b0, 16'h0041);
    step();
    set_sf(1'b1, 1'b1, 16'h0042);
    step();
    set_sf(1'b0, 1'b0, 16'h0);
    #1;
    check("prerst_pkt", sf_pkt, 2);
    check("prerst_fill", sf_fill, 3);
    rst = 1'b1;
    #1;
    check("midrst_fill", sf_fill, 0);
    check("midrst_pkt", sf_pkt, 0);
    check("midrst_valid", sf_out.valid, 0);
    step();
    rst = 1'b0;
    sf_out_ready = 1'b1;
    set_sf(1'b1, 1'b0, 16'h0050);
    #1;
    check("postrst_ready", sf_in_ready, 1);
    step();
    set_sf(1'b1, 1'b1, 16'h0051);
    #1;
    check("postrst_hold", sf_out.valid, 0);
    step();
    set_sf(1'b0, 1'b0, 16'h0);
    #1;
    check("postrst_d0_valid", sf_out.valid, 1);
    check("postrst_d0", sf_out.data, 16'h0050);
    step();
    check("postrst_d1", sf_out.data, 16'h0051);
    check("postrst_d1_last", sf_out.last, 1);
    step();
    check("postrst_empty", sf_fill, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
